// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART memory loader
package uart_loader_pkg;

  localparam logic [15:0] RAM_WORDS = 16'd16384;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    DONE,
    ERROR
  } word_state_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART byte receiver with input synchronizer and glitch rejection
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q, frame_err_q;
  logic [7:0]    data_q;

  assign valid     = valid_q;
  assign data      = data_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= START;
        end
        START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (sync2_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - loads a length-prefixed word stream from UART into memory
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] in,
  output logic        load,
  output logic [14:0] address,
  output logic        active,
  output logic        done,
  output logic        error
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .valid     (rx_valid),
    .data      (rx_data),
    .frame_err (rx_frame_err)
  );

  word_state_e state_q;
  logic [15:0] n_q;
  logic [14:0] cnt_q;
  logic [7:0]  hi_q;
  logic [15:0] in_q;
  logic [14:0] addr_q;
  logic        load_q, active_q, done_q, error_q;
  logic [15:0] hdr_n_d;
  logic        last_word_d;

  assign in      = in_q;
  assign load    = load_q;
  assign address = addr_q;
  assign active  = active_q;
  assign done    = done_q;
  assign error   = error_q;

  always_comb begin
    hdr_n_d     = {n_q[15:8], rx_data};
    last_word_d = ({1'b0, cnt_q} == (n_q - 16'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HDR_HI;
      n_q      <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      in_q     <= '0;
      addr_q   <= '0;
      load_q   <= 1'b0;
      active_q <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      // DONE and ERROR are terminal; nothing on the line can disturb them.
      if (state_q != DONE && state_q != ERROR) begin
        if (rx_frame_err) begin
          state_q  <= ERROR;
          error_q  <= 1'b1;
          active_q <= 1'b0;
        end else if (rx_valid) begin
          case (state_q)
            HDR_HI: begin
              n_q[15:8] <= rx_data;
              state_q   <= HDR_LO;
            end
            HDR_LO: begin
              n_q <= hdr_n_d;
              if (hdr_n_d == 16'd0) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                active_q <= 1'b0;
              end else if (hdr_n_d > RAM_WORDS) begin
                state_q  <= ERROR;
                error_q  <= 1'b1;
                active_q <= 1'b0;
              end else begin
                state_q <= DATA_HI;
              end
            end
            DATA_HI: begin
              hi_q    <= rx_data;
              state_q <= DATA_LO;
            end
            DATA_LO: begin
              in_q   <= {hi_q, rx_data};
              addr_q <= cnt_q;
              load_q <= 1'b1;
              cnt_q  <= cnt_q + 15'd1;
              if (last_word_d) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                active_q <= 1'b0;
              end else begin
                state_q <= DATA_HI;
              end
            end
            default: begin
              state_q  <= ERROR;
              error_q  <= 1'b1;
              active_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed scenario bench for uart_loader at 4 clocks per bit
module tb_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] in_w;
  logic        load_w;
  logic [14:0] addr_w;
  logic        active_w, done_w, error_w;

  int vec = 0;
  int err = 0;

  logic [14:0] la[$];
  logic [15:0] ld[$];
  int          wide = 0;
  int          nvalid = 0;
  logic        load_prev = 1'b0;

  uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .in      (in_w),
    .load    (load_w),
    .address (addr_w),
    .active  (active_w),
    .done    (done_w),
    .error   (error_w)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_w) begin
      la.push_back(addr_w);
      ld.push_back(in_w);
      if (load_prev) wide++;
    end
    if (dut.rx_valid) nvalid++;
    load_prev = load_w;
  end

  task automatic clear_log();
    la.delete();
    ld.delete();
    wide   = 0;
    nvalid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (in_w !== 16'h0000) begin err++; $display("FAIL reset_in: got %h want 0000", in_w); end
    vec++; if (addr_w !== 15'h0000) begin err++; $display("FAIL reset_addr: got %h want 0000", addr_w); end
    vec++; if (load_w !== 1'b0) begin err++; $display("FAIL reset_load: got %b want 0", load_w); end
    vec++; if (done_w !== 1'b0) begin err++; $display("FAIL reset_done: got %b want 0", done_w); end
    vec++; if (error_w !== 1'b0) begin err++; $display("FAIL reset_error: got %b want 0", error_w); end
    vec++; if (active_w !== 1'b1) begin err++; $display("FAIL reset_active: got %b want 1", active_w); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  task automatic test_two_words();
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    settle();
    vec++; if (la.size() !== 2) begin err++; $display("FAIL two_nload: got %0d want 2", la.size()); end
    if (la.size() == 2) begin
      vec++; if (la[0] !== 15'd0) begin err++; $display("FAIL two_addr0: got %h want 0000", la[0]); end
      vec++; if (ld[0] !== 16'h1234) begin err++; $display("FAIL two_in0: got %h want 1234", ld[0]); end
      vec++; if (la[1] !== 15'd1) begin err++; $display("FAIL two_addr1: got %h want 0001", la[1]); end
      vec++; if (ld[1] !== 16'hABCD) begin err++; $display("FAIL two_in1: got %h want abcd", ld[1]); end
    end
    vec++; if (wide !== 0) begin err++; $display("FAIL two_pulse_width: got %0d wide pulses want 0", wide); end
    vec++; if (in_w !== 16'hABCD) begin err++; $display("FAIL two_in_hold: got %h want abcd", in_w); end
    vec++; if (addr_w !== 15'd1) begin err++; $display("FAIL two_addr_hold: got %h want 0001", addr_w); end
    vec++; if (done_w !== 1'b1) begin err++; $display("FAIL two_done: got %b want 1", done_w); end
    vec++; if (active_w !== 1'b0) begin err++; $display("FAIL two_active: got %b want 0", active_w); end
    vec++; if (error_w !== 1'b0) begin err++; $display("FAIL two_error: got %b want 0", error_w); end
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    settle();
    vec++; if (la.size() !== 2) begin err++; $display("FAIL two_after_done: got %0d loads want 2", la.size()); end
  endtask

  task automatic test_empty();
    bit seen;
    apply_reset();
    send_byte(8'h00, 1'b1);
    clear_log();
    fork
      send_byte(8'h00, 1'b1);
    join_none
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dut.rx_valid) seen = 1'b1;
    end
    vec++; if (!seen) begin err++; $display("FAIL empty_valid_timeout: got no byte-valid want one"); end
    if (seen) begin
      vec++; if (done_w !== 1'b0) begin err++; $display("FAIL empty_done_early: got %b want 0", done_w); end
      @(negedge clk);
      vec++; if (done_w !== 1'b1) begin err++; $display("FAIL empty_done_next: got %b want 1", done_w); end
    end
    wait fork;
    settle();
    vec++; if (la.size() !== 0) begin err++; $display("FAIL empty_nload: got %0d want 0", la.size()); end
    vec++; if (active_w !== 1'b0) begin err++; $display("FAIL empty_active: got %b want 0", active_w); end
  endtask

  task automatic test_too_long();
    apply_reset();
    send_byte(8'h40, 1'b1); send_byte(8'h01, 1'b1);
    settle();
    vec++; if (error_w !== 1'b1) begin err++; $display("FAIL long_error: got %b want 1", error_w); end
    vec++; if (active_w !== 1'b0) begin err++; $display("FAIL long_active: got %b want 0", active_w); end
    vec++; if (done_w !== 1'b0) begin err++; $display("FAIL long_done: got %b want 0", done_w); end
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
    settle();
    vec++; if (la.size() !== 0) begin err++; $display("FAIL long_nload: got %0d want 0", la.size()); end
    vec++; if (error_w !== 1'b1) begin err++; $display("FAIL long_sticky: got %b want 1", error_w); end
  endtask

  task automatic test_max_len();
    apply_reset();
    send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    settle();
    vec++; if (error_w !== 1'b0) begin err++; $display("FAIL max_error: got %b want 0", error_w); end
    vec++; if (active_w !== 1'b1) begin err++; $display("FAIL max_active: got %b want 1", active_w); end
  endtask

  task automatic test_frame_err();
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b0);
    settle();
    vec++; if (la.size() !== 1) begin err++; $display("FAIL ferr_nload: got %0d want 1", la.size()); end
    if (la.size() == 1) begin
      vec++; if (ld[0] !== 16'h1234) begin err++; $display("FAIL ferr_in0: got %h want 1234", ld[0]); end
    end
    vec++; if (error_w !== 1'b1) begin err++; $display("FAIL ferr_error: got %b want 1", error_w); end
    vec++; if (active_w !== 1'b0) begin err++; $display("FAIL ferr_active: got %b want 0", active_w); end
    vec++; if (done_w !== 1'b0) begin err++; $display("FAIL ferr_done: got %b want 0", done_w); end
  endtask

  task automatic test_glitch();
    apply_reset();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    settle();
    vec++; if (nvalid !== 0) begin err++; $display("FAIL glitch_valid: got %0d byte-valids want 0", nvalid); end
    vec++; if (error_w !== 1'b0) begin err++; $display("FAIL glitch_error: got %b want 0", error_w); end
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    settle();
    vec++; if (la.size() !== 1) begin err++; $display("FAIL glitch_nload: got %0d want 1", la.size()); end
    if (la.size() == 1) begin
      vec++; if (la[0] !== 15'd0) begin err++; $display("FAIL glitch_addr: got %h want 0000", la[0]); end
      vec++; if (ld[0] !== 16'hBEEF) begin err++; $display("FAIL glitch_in: got %h want beef", ld[0]); end
    end
    vec++; if (done_w !== 1'b1) begin err++; $display("FAIL glitch_done: got %b want 1", done_w); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    settle();
    vec++; if (la.size() !== 2) begin err++; $display("FAIL mid_pre_nload: got %0d want 2", la.size()); end
    vec++; if (addr_w !== 15'd1) begin err++; $display("FAIL mid_pre_addr: got %h want 0001", addr_w); end
    @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    vec++; if (in_w !== 16'h0000) begin err++; $display("FAIL mid_rst_in: got %h want 0000", in_w); end
    vec++; if (addr_w !== 15'd0) begin err++; $display("FAIL mid_rst_addr: got %h want 0000", addr_w); end
    vec++; if (active_w !== 1'b1) begin err++; $display("FAIL mid_rst_active: got %b want 1", active_w); end
    vec++; if (load_w !== 1'b0) begin err++; $display("FAIL mid_rst_load: got %b want 0", load_w); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1);
    settle();
    vec++; if (la.size() !== 1) begin err++; $display("FAIL mid_post_nload: got %0d want 1", la.size()); end
    if (la.size() == 1) begin
      vec++; if (la[0] !== 15'd0) begin err++; $display("FAIL mid_post_addr: got %h want 0000", la[0]); end
      vec++; if (ld[0] !== 16'h0007) begin err++; $display("FAIL mid_post_in: got %h want 0007", ld[0]); end
    end
    vec++; if (done_w !== 1'b1) begin err++; $display("FAIL mid_post_done: got %b want 1", done_w); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_empty();
    test_too_long();
    test_max_len();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 104, clk cycles per UART bit (115200 baud at 12 MHz); SHALL be at least 4.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  UART receive line, idle high, asynchronous to clk.
REQ-005 in  output  16  write data presented to the Memory in port.
REQ-006 load  output  1  one-cycle write strobe to the Memory load port.
REQ-007 address  output  15  word address to the Memory address port.
REQ-008 active  output  1  high while the loader owns the memory bus; the CPU is held in reset while it is high.
REQ-009 done  output  1  high once every announced word has been written; sticky.
REQ-010 error  output  1  high on a framing or length error; sticky.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Byte receive: a falling edge on the synchronized rx in idle starts a frame.
REQ-013 rx SHALL be resampled at CLKS_PER_BIT/2; if it is high, the event is a glitch and the receiver returns to idle with no error.
REQ-014 The receiver then samples 8 data bits, LSB first, and the stop bit, each CLKS_PER_BIT apart at mid-bit.
REQ-015 A valid stop bit (high) SHALL produce a one-cycle byte-valid pulse with the 8-bit value.
REQ-016 A stop bit sampled low SHALL set error.
REQ-017 Stream format: a 16-bit word count N (high byte first), then N data words (high byte first).
REQ-018 Word FSM states: HDR_HI, HDR_LO, DATA_HI, DATA_LO, DONE, ERROR; each byte-valid advances exactly one state.
REQ-019 HDR_HI -> HDR_LO stores N[15:8].
REQ-020 HDR_LO stores N[7:0] and then branches: N = 0 -> DONE; N > 16384 -> ERROR; otherwise -> DATA_HI.
REQ-021 DATA_HI -> DATA_LO stores the high byte.
REQ-022 In DATA_LO, on byte-valid, in SHALL equal {high byte, low byte} and load SHALL pulse high for exactly one cycle, in the cycle after the byte-valid pulse.
REQ-023 address SHALL equal the word counter during the load pulse; the counter starts at 0 and increments by 1 after each load.
REQ-024 After word N-1 is written the FSM SHALL enter DONE; otherwise it returns to DATA_HI.
REQ-025 address never exceeds 16383, so address[14] is always 0 and every write lands in RAM.
REQ-026 active = 1 in all states except DONE and ERROR.
REQ-027 done = 1 only in DONE; error = 1 only in ERROR.
REQ-028 In DONE and ERROR, further rx traffic SHALL be ignored (no load pulses); only reset leaves these states.
REQ-029 A framing error in any state SHALL force ERROR with load low.
REQ-030 in and address SHALL hold their last values when load is low.

Reset
REQ-031 Reset SHALL put the receiver in idle and the word FSM in HDR_HI.
REQ-032 Reset values: counter = 0, in = 0, address = 0, load = 0, done = 0, error = 0, active = 1.
REQ-033 Synchronizer flops SHALL reset to 1 (idle line).
REQ-034 Reset asserted mid-frame or mid-word SHALL abort with no load pulse; the next frame after release is treated as HDR_HI.

Structure
REQ-035 Shared package uart_loader_pkg SHALL hold the word-FSM state enum, RAM_WORDS = 16384, and the receiver state enum (IDLE, START, DATA, STOP).
REQ-036 Byte reception SHALL be one sub-module, uart_rx (ports clk, reset, rx, valid, data[7:0], frame_err); uart_loader instantiates it and holds the word FSM, counter and outputs.

Verification (CLKS_PER_BIT = 4)
REQ-037 Bytes 00 02 12 34 AB CD -> load pulses at address 0 with in = 0x1234, then at address 1 with in = 0xABCD; then done = 1, active = 0.
REQ-038 Header 00 00 -> no load pulse; done = 1 one cycle after the second byte-valid.
REQ-039 Header 40 01 (N = 16385) -> error = 1, active = 0, no load; subsequent bytes -> no load.
REQ-040 Second data byte sent with its stop bit low -> error = 1, no load for that word; the earlier word remains written.
REQ-041 rx low pulse of 1 cycle in idle -> no byte-valid, no error; a following valid stream 00 01 BE EF -> one load, address 0, in = 0xBEEF.
REQ-042 Reset asserted during DATA_LO of word 3 of N = 5 -> all outputs return to reset values; a new stream 00 01 00 07 -> load at address 0 with in = 0x0007, done = 1.
